serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// +-----------------------------------------------------------------+
// | serial_sub_pkg : shared state encoding and default width        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// +-----------------------------------------------------------------+
// | FullSubtractor : one-bit combinational x - y - borrow cell      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module FullSubtractor (
  input  logic in1,
  input  logic in2,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = in1 ^ in2 ^ b_in;
  assign b_out = (~in1 & in2) | (~(in1 ^ in2) & b_in);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +-----------------------------------------------------------------+
// | serial_subtractor : bit-serial a - b - b_in, LSB first          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_bit;
  logic             w_borrow_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  FullSubtractor u_cell (
    .in1  (r_a_sr[0]),
    .in2  (r_b_sr[0]),
    .b_in (r_borrow),
    .diff (w_bit),
    .b_out(w_borrow_nxt)
  );

  assign w_last    = (r_cnt == C_LAST);
  assign w_res_nxt = {w_bit, r_res_sr[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      b_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_SHIFT);
      done    <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_res_sr <= '0;
            r_borrow <= b_in;
            r_cnt    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_nxt;
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            diff     <= w_res_nxt;
            b_out    <= w_borrow_nxt;
            // Overflow only possible when operand signs differ
            overflow <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +-----------------------------------------------------------------+
// | tb_serial_subtractor : directed vectors for serial_subtractor   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .b_out   (b_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch at E0, then follow the operation to its done pulse
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vbin);
    a = va; b = vb; b_in = vbin; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20 && cyc == 0; i++) begin
      tick();
      if (done) cyc = i;
    end
    check({tag, "_latency"}, cyc, WIDTH);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vbin, input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    int cyc;
    launch(va, vb, vbin);
    wait_done(tag, cyc);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_b_out"}, b_out, eb);
    check({tag, "_ovf"}, overflow, eo);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_diff_hold"}, diff, ed);
  endtask

  initial begin
    int cyc;
    int n_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_b_out", b_out, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    run_op("basic",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("under",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("bin",     8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("mixed",   8'hC3, 8'h5A, 1'b1, 8'h68, 1'b0, 1'b1);

    // start pulse during SHIFT must be ignored
    launch(8'h10, 8'h01, 1'b0);
    tick(); tick(); tick();
    a = 8'hAA; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        n_done++;
        check("busy_ign_diff", diff, 8'h0F);
      end
      tick();
    end
    check("busy_ign_ndone", n_done, 1);
    check("busy_ign_idle", busy, 0);

    // reset in the middle of SHIFT
    launch(8'hF0, 8'h0F, 1'b0);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_b_out", b_out, 0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("mid_rst_quiet", n_done, 0);
    run_op("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // back-to-back: start sampled at E_WIDTH+1
    start = 1'b1; a = 8'h20; b = 8'h10; b_in = 1'b0;
    tick();
    check("b2b_busy", busy, 1);
    start = 1'b0;
    wait_done("b2b", cyc);
    check("b2b_diff", diff, 8'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
